// File: rtl/counter4_pkg.sv
// ============================================================================
// Module      : counter4_pkg
// Description : Shared constants and the Gray encoding helper for counter4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter4_pkg;

    localparam int c_max_width = 32;

    // Masked so that callers narrower than c_max_width get a clean result.
    function automatic logic [c_max_width-1:0] gray_enc(
        input logic [c_max_width-1:0] value,
        input int                     width
    );
        logic [c_max_width-1:0] mask;
        mask = (width >= c_max_width) ? '1 : ((c_max_width'(1) << width) - c_max_width'(1));
        return (value ^ (value >> 1)) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter4_bin2gray.sv
// ============================================================================
// Module      : bin2gray
// Description : Combinational binary-to-Gray encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2gray
    import counter4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = WIDTH'(gray_enc(c_max_width'(i_bin), WIDTH));

endmodule

`default_nettype wire

// File: rtl/counter4.sv
// ============================================================================
// Module      : counter4
// Description : Free-running up-counter with terminal count, wrap pulse and
//               registered Gray-coded copy of the count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter4
    import counter4_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_gray,
    output logic             tc,
    output logic             wrap
);

    localparam longint unsigned c_full_max = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_VAL);

    generate
        if (WIDTH < 1 || WIDTH > c_max_width) begin : g_bad_width
            $fatal(1, "counter4: WIDTH must be within 1..32");
        end
        if (MAX_VAL > c_full_max) begin : g_bad_max
            $fatal(1, "counter4: MAX_VAL must fit in WIDTH bits");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_q_gray;
    logic             r_wrap;
    logic             r_armed;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_gray_next;
    logic             w_tc;

    assign w_tc     = (r_q == c_max);
    assign w_q_next = w_tc ? '0 : r_q + WIDTH'(1);

    // Encoding the next state keeps q_gray aligned with q in the same cycle.
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (w_q_next),
        .o_gray (w_q_gray_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            r_q_gray <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_q      <= w_q_next;
            r_q_gray <= w_q_gray_next;
            r_wrap   <= w_tc;
        end
    end

    // Marks that reset has been applied at least once; gates the checks below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b1;
        end
    end

    assign q      = r_q;
    assign q_gray = r_q_gray;
    assign tc     = w_tc;
    assign wrap   = r_wrap;

    a_range : assert property (@(posedge clk) disable iff (rst)
        r_armed |-> (r_q <= c_max));

    generate
        // A truncated range wraps across several bits, so only full range is single-step.
        if (MAX_VAL == c_full_max) begin : g_gray_chk
            a_gray_step : assert property (@(posedge clk) disable iff (rst)
                (r_armed && !$past(rst)) |-> $onehot(r_q_gray ^ $past(r_q_gray)));
        end
        if (MAX_VAL != 0) begin : g_wrap_chk
            a_wrap_pulse : assert property (@(posedge clk) disable iff (rst)
                r_wrap |=> !r_wrap);
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_counter4.sv
// ============================================================================
// Module      : tb_counter4
// Description : Self-checking bench for counter4 (full range and MAX_VAL=9).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter4;

    logic       clk;
    logic       r_rst_a;
    logic       r_rst_b;
    logic [3:0] w_q_a, w_gray_a, w_q_b, w_gray_b;
    logic       w_tc_a, w_wrap_a, w_tc_b, w_wrap_b;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Edges since the last reset edge, per instance.
    int n_a = 0;
    int n_b = 0;

    localparam int c_per_a = 16;
    localparam int c_per_b = 10;

    counter4 u_dut_a (
        .clk    (clk),
        .rst    (r_rst_a),
        .q      (w_q_a),
        .q_gray (w_gray_a),
        .tc     (w_tc_a),
        .wrap   (w_wrap_a)
    );

    counter4 #(
        .WIDTH   (4),
        .MAX_VAL (9)
    ) u_dut_b (
        .clk    (clk),
        .rst    (r_rst_b),
        .q      (w_q_b),
        .q_gray (w_gray_b),
        .tc     (w_tc_b),
        .wrap   (w_wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        n_a <= r_rst_a ? 0 : n_a + 1;
        n_b <= r_rst_b ? 0 : n_b + 1;
    end

    function automatic logic [3:0] exp_q(input int n, input int per);
        return 4'(n % per);
    endfunction

    function automatic logic exp_wrap(input int n, input int per);
        return (n > 0) && (n % per == 0);
    endfunction

    function automatic logic [3:0] exp_gray(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic note(input bit ok, input string name, input int act, input int req);
        checks++;
        if (ok) passed++;
        else begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic test_reset();
        r_rst_a = 1'b1;
        r_rst_b = 1'b1;
        tick();
        tick();
        note(w_q_a === 4'd0, "reset_q_a", w_q_a, 0);
        note(w_gray_a === 4'd0, "reset_gray_a", w_gray_a, 0);
        note(w_wrap_a === 1'b0, "reset_wrap_a", w_wrap_a, 0);
        note(w_tc_a === 1'b0, "reset_tc_a", w_tc_a, 0);
        note(w_q_b === 4'd0, "reset_q_b", w_q_b, 0);
        note(w_wrap_b === 1'b0, "reset_wrap_b", w_wrap_b, 0);
    endtask

    task automatic test_count();
        r_rst_a = 1'b0;
        r_rst_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] kv;
            kv = 4'(k);
            tick();
            note(w_q_a === kv, "count_q", w_q_a, k);
            note(w_gray_a === (kv ^ (kv >> 1)), "count_gray", w_gray_a, kv ^ (kv >> 1));
            note(w_wrap_a === 1'b0, "count_wrap", w_wrap_a, 0);
        end
    endtask

    task automatic test_wrap_full();
        for (int k = 0; k < 5; k++) tick();
        note(w_q_a === 4'd15, "full_q15", w_q_a, 15);
        note(w_tc_a === 1'b1, "full_tc_at15", w_tc_a, 1);
        note(w_wrap_a === 1'b0, "full_wrap_at15", w_wrap_a, 0);
        tick();
        note(w_q_a === 4'd0, "full_q_wrapped", w_q_a, 0);
        note(w_wrap_a === 1'b1, "full_wrap_pulse", w_wrap_a, 1);
        note(w_tc_a === 1'b0, "full_tc_after", w_tc_a, 0);
        tick();
        note(w_wrap_a === 1'b0, "full_wrap_single", w_wrap_a, 0);
    endtask

    task automatic test_custom();
        int wraps = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            note(w_q_b === exp_q(n_b, c_per_b), "custom_q", w_q_b, exp_q(n_b, c_per_b));
            note(w_q_b <= 4'd9, "custom_range", w_q_b, 9);
            note(w_tc_b === (exp_q(n_b, c_per_b) == 4'd9), "custom_tc", w_tc_b, exp_q(n_b, c_per_b) == 4'd9);
            note(w_wrap_b === exp_wrap(n_b, c_per_b), "custom_wrap", w_wrap_b, exp_wrap(n_b, c_per_b));
            if (w_wrap_b === 1'b1) wraps++;
        end
        note(wraps == 3, "custom_wrap_count", wraps, 3);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (exp_q(n_a, c_per_a) != 4'd7 && guard < 40) begin
            tick();
            guard++;
        end
        note(guard < 40, "mid_wait_q7", guard, 40);
        note(w_q_a === 4'd7, "mid_q7", w_q_a, 7);
        r_rst_a = 1'b1;
        tick();
        r_rst_a = 1'b0;
        note(w_q_a === 4'd0, "mid_q0", w_q_a, 0);
        note(w_wrap_a === 1'b0, "mid_wrap0", w_wrap_a, 0);
        note(w_gray_a === 4'd0, "mid_gray0", w_gray_a, 0);
        tick();
        note(w_q_a === 4'd1, "mid_resume1", w_q_a, 1);
        tick();
        note(w_q_a === 4'd2, "mid_resume2", w_q_a, 2);
    endtask

    task automatic test_reset_terminal();
        int guard = 0;
        while ((exp_q(n_a, c_per_a) != 4'd15 || exp_q(n_b, c_per_b) != 4'd9) && guard < 200) begin
            tick();
            guard++;
        end
        note(guard < 200, "term_wait", guard, 200);
        note(w_tc_a === 1'b1, "term_tc_a", w_tc_a, 1);
        note(w_tc_b === 1'b1, "term_tc_b", w_tc_b, 1);
        r_rst_a = 1'b1;
        r_rst_b = 1'b1;
        tick();
        r_rst_a = 1'b0;
        r_rst_b = 1'b0;
        note(w_q_a === 4'd0, "term_q_a", w_q_a, 0);
        note(w_wrap_a === 1'b0, "term_wrap_a", w_wrap_a, 0);
        note(w_q_b === 4'd0, "term_q_b", w_q_b, 0);
        note(w_wrap_b === 1'b0, "term_wrap_b", w_wrap_b, 0);
        tick();
        note(w_wrap_a === 1'b0, "term_wrap_a_next", w_wrap_a, 0);
        note(w_q_a === 4'd1, "term_q_a_next", w_q_a, 1);
    endtask

    task automatic test_gray();
        logic [3:0] prev;
        prev = w_gray_a;
        for (int k = 0; k < 2 * c_per_a; k++) begin
            tick();
            note($countones(w_gray_a ^ prev) == 1, "gray_step", w_gray_a, prev);
            note(w_gray_a === exp_gray(exp_q(n_a, c_per_a)), "gray_value", w_gray_a, exp_gray(exp_q(n_a, c_per_a)));
            prev = w_gray_a;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            r_rst_a = ($urandom_range(0, 15) == 0);
            r_rst_b = ($urandom_range(0, 15) == 0);
            tick();
            note(w_q_a === exp_q(n_a, c_per_a), "rand_q_a", w_q_a, exp_q(n_a, c_per_a));
            note(w_gray_a === exp_gray(exp_q(n_a, c_per_a)), "rand_gray_a", w_gray_a, exp_gray(exp_q(n_a, c_per_a)));
            note(w_tc_a === (exp_q(n_a, c_per_a) == 4'd15), "rand_tc_a", w_tc_a, exp_q(n_a, c_per_a) == 4'd15);
            note(w_wrap_a === exp_wrap(n_a, c_per_a), "rand_wrap_a", w_wrap_a, exp_wrap(n_a, c_per_a));
            note(w_q_b === exp_q(n_b, c_per_b), "rand_q_b", w_q_b, exp_q(n_b, c_per_b));
            note(w_gray_b === exp_gray(exp_q(n_b, c_per_b)), "rand_gray_b", w_gray_b, exp_gray(exp_q(n_b, c_per_b)));
            note(w_tc_b === (exp_q(n_b, c_per_b) == 4'd9), "rand_tc_b", w_tc_b, exp_q(n_b, c_per_b) == 4'd9);
            note(w_wrap_b === exp_wrap(n_b, c_per_b), "rand_wrap_b", w_wrap_b, exp_wrap(n_b, c_per_b));
        end
        r_rst_a = 1'b0;
        r_rst_b = 1'b0;
    endtask

    initial begin
        r_rst_a = 1'b1;
        r_rst_b = 1'b1;
        test_reset();
        test_count();
        test_wrap_full();
        test_custom();
        test_reset_mid();
        test_reset_terminal();
        test_gray();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
